// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the front end of the RISC-V core.
package pipe_pkg;

   typedef enum logic [0:0] {
      F_RUN    = 1'b0,
      F_HALTED = 1'b1
   } fetch_state_e;

   localparam int          IF_ID_PC_W = 32;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
   localparam int          PC_INCR    = 4;

   typedef struct packed {
      logic [31:0]           instr;
      logic [IF_ID_PC_W-1:0] pc;
      logic                  valid;
   } if_id_t;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch and stall event counters; present only when FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_fetch_inc,
   input  logic        i_stall_inc,
   output logic [31:0] o_fetch_cnt,
   output logic [31:0] o_stall_cnt
);

   logic [31:0] r_fetch_cnt;
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_cnt <= 32'd0;
         r_stall_cnt <= 32'd0;
      end else begin
         if (i_fetch_inc) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         end
         if (i_stall_inc) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign o_fetch_cnt = r_fetch_cnt;
   assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC register, IF/ID pipeline register and halt FSM.
// Optional performance counters are enabled with FETCH_PERF_CNT_EN.
module fetch_stage #(
   parameter int                 PC_W      = 32,
   parameter logic [PC_W-1:0]    RESET_PC  = {PC_W{1'b0}},
   parameter logic [31:0]        NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            reset,
   output logic [PC_W-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic [PC_W-1:0] target_i,
   input  logic            halt_i,
   output logic [31:0]     if_id_instr,
   output logic [PC_W-1:0] if_id_pc,
   output logic            if_id_valid,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]     perf_fetch_cnt,
   output logic [31:0]     perf_stall_cnt,
`endif
   output logic            halted_o
);

   import pipe_pkg::*;

   fetch_state_e    r_state;
   logic [PC_W-1:0] r_pc;
   if_id_t          r_if_id;
   logic            r_halted;
   logic [PC_W-1:0] w_target_aligned;

   assign w_target_aligned = {target_i[PC_W-1:2], 2'b00};

   // Priority in F_RUN: flush > halt > stall > advance; F_HALTED leaves only via reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= F_RUN;
         r_pc     <= RESET_PC;
         r_if_id  <= '{instr: NOP_INSTR, pc: {IF_ID_PC_W{1'b0}}, valid: 1'b0};
         r_halted <= 1'b0;
      end else begin
         case (r_state)
            F_RUN: begin
               if (flush_i) begin
                  r_pc          <= w_target_aligned;
                  r_if_id.instr <= NOP_INSTR;
                  r_if_id.valid <= 1'b0;
               end else if (halt_i) begin
                  r_if_id.instr <= NOP_INSTR;
                  r_if_id.valid <= 1'b0;
                  r_state       <= F_HALTED;
                  r_halted      <= 1'b1;
               end else if (stall_i) begin
                  r_pc    <= r_pc;
                  r_if_id <= r_if_id;
               end else begin
                  r_if_id.instr <= imem_rdata;
                  r_if_id.pc    <= IF_ID_PC_W'(r_pc);
                  r_if_id.valid <= 1'b1;
                  r_pc          <= r_pc + PC_W'(PC_INCR);
               end
            end
            F_HALTED: begin
               r_halted <= 1'b1;
            end
            default: begin
               r_state       <= F_HALTED;
               r_halted      <= 1'b1;
               r_if_id.instr <= NOP_INSTR;
               r_if_id.valid <= 1'b0;
            end
         endcase
      end
   end

   assign imem_addr   = r_pc;
   assign if_id_instr = r_if_id.instr;
   assign if_id_pc    = r_if_id.pc[PC_W-1:0];
   assign if_id_valid = r_if_id.valid;
   assign halted_o    = r_halted;

`ifdef FETCH_PERF_CNT_EN
   logic w_fetch_inc;
   logic w_stall_inc;

   always_comb begin
      w_fetch_inc = 1'b0;
      w_stall_inc = 1'b0;
      if (r_state == F_RUN) begin
         w_fetch_inc = ~flush_i & ~halt_i & ~stall_i;
         w_stall_inc = ~flush_i & ~halt_i & stall_i;
      end else begin
         w_fetch_inc = 1'b0;
         w_stall_inc = 1'b0;
      end
   end

   fetch_perf_cnt u_perf (
      .clk         (clk),
      .reset       (reset),
      .i_fetch_inc (w_fetch_inc),
      .i_stall_inc (w_stall_inc),
      .o_fetch_cnt (perf_fetch_cnt),
      .o_stall_cnt (perf_stall_cnt)
   );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized traffic vs a cycle model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] target_i;
   logic        halt_i;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic        if_id_valid;
   logic        halted_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   int total = 0;
   int bad   = 0;

   logic [31:0] m_pc, m_instr, m_ifpc, m_fc, m_sc;
   logic        m_valid, m_halted;

   always #5 clk = ~clk;

   // Instruction memory: every address returns a distinct word.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5C3_5A3C;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .stall_i     (stall_i),
      .flush_i     (flush_i),
      .target_i    (target_i),
      .halt_i      (halt_i),
      .if_id_instr (if_id_instr),
      .if_id_pc    (if_id_pc),
      .if_id_valid (if_id_valid),
`ifdef FETCH_PERF_CNT_EN
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt),
`endif
      .halted_o    (halted_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("imem_addr", imem_addr, m_pc);
      check("if_id_instr", if_id_instr, m_instr);
      check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
      check("halted_o", {31'd0, halted_o}, {31'd0, m_halted});
      if (m_valid) check("if_id_pc", if_id_pc, m_ifpc);
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetch_cnt", perf_fetch_cnt, m_fc);
      check("perf_stall_cnt", perf_stall_cnt, m_sc);
`endif
   endtask

   // One clock: apply inputs, advance the reference model by the spec rules, compare.
   task automatic step(input logic r, input logic f, input logic h, input logic s,
                       input logic [31:0] t);
      logic [31:0] word;
      reset = r; flush_i = f; halt_i = h; stall_i = s; target_i = t;
      word = mem_word(m_pc);
      @(posedge clk);
      if (r) begin
         m_pc = 32'h0; m_instr = 32'h13; m_ifpc = 32'h0; m_valid = 1'b0;
         m_halted = 1'b0; m_fc = 32'd0; m_sc = 32'd0;
      end else if (!m_halted) begin
         if (f) begin
            m_pc = t & 32'hFFFF_FFFC; m_instr = 32'h13; m_valid = 1'b0;
         end else if (h) begin
            m_instr = 32'h13; m_valid = 1'b0; m_halted = 1'b1;
         end else if (s) begin
            m_sc = m_sc + 32'd1;
         end else begin
            m_instr = word; m_ifpc = m_pc; m_valid = 1'b1;
            m_pc = m_pc + 32'd4; m_fc = m_fc + 32'd1;
         end
      end
      #1;
      check_all();
   endtask

   initial begin
      reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0; halt_i = 1'b0; target_i = 32'h0;
      m_pc = 32'h0; m_instr = 32'h13; m_ifpc = 32'h0; m_valid = 1'b0;
      m_halted = 1'b0; m_fc = 32'd0; m_sc = 32'd0;

      // Reset state
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      check("reset_if_id_pc", if_id_pc, 32'h0);

      // Free run: addresses 4, 8, 0xC
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check("freerun_addr", imem_addr, 32'h0000_000C);
      check("freerun_ifpc", if_id_pc, 32'h0000_0008);

      // Stall two cycles at pc=8
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      check("stall_addr", imem_addr, 32'h0000_0008);
      check("stall_ifpc", if_id_pc, 32'h0000_0004);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

      // Flush with unaligned target
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0103);
      check("flush_addr", imem_addr, 32'h0000_0100);
      check("flush_instr", if_id_instr, 32'h0000_0013);

      // Flush beats halt and stall
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0020);
      check("flush_prio_halt", {31'd0, halted_o}, 32'd0);
      check("flush_prio_addr", imem_addr, 32'h0000_0020);

      // Halt at 0x20, then frozen despite flush pulses
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      check("halt_flag", {31'd0, halted_o}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, (i % 2) == 0, 1'b0, (i % 3) == 0, 32'h0000_0400);
         check("halt_frozen_pc", imem_addr, 32'h0000_0020);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      check("halt_reset_pc", imem_addr, 32'h0);

      // PC wrap at top of address space
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      check("wrap_addr", imem_addr, 32'h0);
      check("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);

      // 5 advances + 2 stalls from reset
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, (i == 2) || (i == 5), 32'h0);
      check("seq_addr", imem_addr, 32'h0000_0014);
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetch_5", perf_fetch_cnt, 32'd5);
      check("perf_stall_2", perf_stall_cnt, 32'd2);
`endif

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10,
              $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 25, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
